disp_mux_ctrl: RTL and testbench
================================

DISP_MUX_CTRL -- requirements
Module: disp_mux_ctrl

Interface
REQ-001 Parameter REFRESH_CYCLES, 24000, clk cycles each digit is lit per scan slot; legal range 2 or more.
REQ-002 Parameter DEAD_CYCLES, 240, blanking clk cycles between digit slots; legal range 2 or more.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 digit_in  input  4  hex value offered by the upstream source (keypad path).
REQ-006 digit_valid  input  1  digit_in is valid this cycle.
REQ-007 digit_ready  output  1  block accepts digit_in this cycle.
REQ-008 clear  input  1  synchronous clear of both displayed digits.
REQ-009 hex_sel  output  4  digit value presented to the external shared seven-segment decoder.
REQ-010 seg_code  input  7  combinational decoder result for hex_sel, {g,f,e,d,c,b,a}, active-low.
REQ-011 seg  output  7  registered segment drive, {g,f,e,d,c,b,a}, active-low.
REQ-012 an_n  output  2  registered anode enables, active-low; bit0 is the right digit and bit1 is the left digit.

Function
REQ-013 The FSM SHALL cycle through SHOW0 -> DEAD0 -> SHOW1 -> DEAD1 -> SHOW0, with one shared down-counter reloaded on every transition.
REQ-014 Each SHOW state SHALL last exactly REFRESH_CYCLES cycles and each DEAD state exactly DEAD_CYCLES cycles, so the scan period is 2*(REFRESH_CYCLES+DEAD_CYCLES).
REQ-015 hex_sel SHALL be combinational from state: d0 (right) in SHOW0/DEAD1, d1 (left) in SHOW1/DEAD0.
REQ-016 Each cycle, seg SHALL register seg_code when state is SHOW0/SHOW1, else 7'b1111111.
REQ-017 Each cycle, an_n SHALL register 2'b10 in SHOW0, 2'b01 in SHOW1, else 2'b11, giving both outputs an identical one-cycle lag from state.
REQ-018 an_n SHALL never equal 2'b00.
REQ-019 digit_ready SHALL equal NOT pend_valid when reset is high.
REQ-020 digit_valid AND digit_ready SHALL capture digit_in into pend and set pend_valid.
REQ-021 digit_valid while digit_ready is low SHALL be ignored; the upstream source holds valid until ready.
REQ-022 On the first cycle of DEAD0 or DEAD1 with pend_valid set, the block SHALL shift d1<=d0, d0<=pend and clear pend_valid.
REQ-023 Committed digits SHALL never change while a digit is lit.
REQ-024 clear SHALL set d0=d1=0 and pend_valid=0 next cycle, with priority over both commit and capture in the same cycle.
REQ-025 clear SHALL NOT alter FSM state or counter.

Reset
REQ-026 While reset is low, next edge SHALL give: state=DEAD1, counter=DEAD_CYCLES, d0=d1=0, pend_valid=0, seg=7'b1111111, an_n=2'b11, and digit_ready SHALL be 0 combinationally.
REQ-027 Reset asserted mid-scan, including in SHOW states, SHALL blank outputs on the next edge and discard any pending digit.
REQ-028 After reset releases, SHOW0 SHALL begin after DEAD_CYCLES cycles.

Structure
REQ-029 Package disp_pkg SHALL hold the state enum typedef, SEG_BLANK=7'b1111111, AN_OFF=2'b11, and default REFRESH_CYCLES/DEAD_CYCLES constants.
REQ-030 One sub-module, scan_timer, SHALL implement a loadable down-counter with a zero flag.
REQ-031 The seven-segment decoder SHALL remain external and shared; it SHALL NOT be instantiated inside this block.

Verification (REFRESH_CYCLES=4, DEAD_CYCLES=2)
REQ-032 Reset low for 3 cycles, then high, no digits -> seg=1111111 and an_n=11 until 3 edges after release; then repeating pattern an_n=10 x4, 11 x2, 01 x4, 11 x2, with seg=1000000 whenever a digit is lit.
REQ-033 Offer 0x3, then 0xA after its acceptance -> after both DEAD commits, right digit hex_sel=A and left digit hex_sel=3; lit seg follows the decoder code for A and 3.
REQ-034 Hold digit_valid with 0x5 then 0x6 back-to-back -> ready drops after 0x5, rises the cycle after the next DEAD-entry commit, and 0x6 is then accepted with no digit lost; final state left=5, right=6.
REQ-035 Assert clear in the same cycle as digit_valid=1 with ready=1, digits 3/A -> both digits 0, pend_valid=0, offered digit discarded, ready=1 next cycle.
REQ-036 Drop reset during SHOW1 with a pending digit -> next edge gives an_n=11, seg=1111111, digits 0, pend dropped.
REQ-037 All scenarios -> an_n never 00, at least DEAD_CYCLES blank cycles between lit windows, and lit seg never changes within a window.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed two-digit seven-segment display controller.
package disp_pkg;

  typedef enum logic [1:0] {
    StShow0,
    StDead0,
    StShow1,
    StDead1
  } disp_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [1:0] AN_OFF    = 2'b11;

  localparam int unsigned DEFAULT_REFRESH_CYCLES = 24000;
  localparam int unsigned DEFAULT_DEAD_CYCLES    = 240;

endpackage

// File: rtl/disp_mux_ctrl_if.sv
// Upstream digit handshake plus clear, shared between the keypad source and the display block.
interface disp_mux_ctrl_if;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;
  logic       clear;

  modport master (
    output digit_in,
    output digit_valid,
    output clear,
    input  digit_ready
  );

  modport slave (
    input  digit_in,
    input  digit_valid,
    input  clear,
    output digit_ready
  );
endinterface

// File: rtl/scan_timer.sv
// Loadable down-counter pacing the display scan slots; zero_o marks the final cycle of a slot.
module scan_timer #(
  parameter int unsigned Width    = 16,
  parameter int unsigned ResetVal = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] cnt_o,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - Width'(1);
    if (load_i) begin
      cnt_d = load_val_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= Width'(ResetVal);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  // The count holds the cycles left in the slot, so it reaches zero at this edge.
  assign zero_o = (cnt_q == Width'(1));

endmodule

// File: rtl/disp_mux_ctrl.sv
// Two-digit multiplexed display scanner with blanking slots and a one-deep digit input buffer.
module disp_mux_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = DEFAULT_REFRESH_CYCLES,
  parameter int unsigned DEAD_CYCLES    = DEFAULT_DEAD_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  disp_mux_ctrl_if.slave        up,
  output logic            [3:0] hex_sel,
  input  logic            [6:0] seg_code,
  output logic            [6:0] seg,
  output logic            [1:0] an_n
);

  localparam int unsigned MaxCycles = (REFRESH_CYCLES > DEAD_CYCLES) ? REFRESH_CYCLES : DEAD_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  disp_state_e     state_q, state_d;
  logic [CntW-1:0] cnt, load_val;
  logic            slot_end;
  logic [3:0]      d0_q, d0_d, d1_q, d1_d, pend_q, pend_d;
  logic            pend_valid_q, pend_valid_d;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      an_n_q, an_n_d;
  logic            first_dead, capture;

  scan_timer #(
    .Width    (CntW),
    .ResetVal (DEAD_CYCLES)
  ) u_scan_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (slot_end),
    .load_val_i (load_val),
    .cnt_o      (cnt),
    .zero_o     (slot_end)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StShow0: if (slot_end) state_d = StDead0;
      StDead0: if (slot_end) state_d = StShow1;
      StShow1: if (slot_end) state_d = StDead1;
      StDead1: if (slot_end) state_d = StShow0;
      default: state_d = StDead1;
    endcase
    load_val = ((state_d == StShow0) || (state_d == StShow1)) ? CntW'(REFRESH_CYCLES)
                                                               : CntW'(DEAD_CYCLES);
  end

  assign hex_sel = ((state_q == StShow0) || (state_q == StDead1)) ? d0_q : d1_q;

  // Commits land only while blanked so a lit digit never changes under the viewer.
  assign first_dead     = ((state_q == StDead0) || (state_q == StDead1)) &&
                          (cnt == CntW'(DEAD_CYCLES));
  assign up.digit_ready = reset & ~pend_valid_q;
  assign capture        = up.digit_valid & up.digit_ready;

  always_comb begin
    d0_d         = d0_q;
    d1_d         = d1_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (up.clear) begin
      d0_d         = 4'h0;
      d1_d         = 4'h0;
      pend_valid_d = 1'b0;
    end else if (first_dead && pend_valid_q) begin
      d1_d         = d0_q;
      d0_d         = pend_q;
      pend_valid_d = 1'b0;
    end else if (capture) begin
      pend_d       = up.digit_in;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    seg_d  = SEG_BLANK;
    an_n_d = AN_OFF;
    if (state_q == StShow0) begin
      seg_d  = seg_code;
      an_n_d = 2'b10;
    end else if (state_q == StShow1) begin
      seg_d  = seg_code;
      an_n_d = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StDead1;
      d0_q         <= 4'h0;
      d1_q         <= 4'h0;
      pend_q       <= 4'h0;
      pend_valid_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_n_q       <= AN_OFF;
    end else begin
      state_q      <= state_d;
      d0_q         <= d0_d;
      d1_q         <= d1_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      an_n_q       <= an_n_d;
    end
  end

  assign seg  = seg_q;
  assign an_n = an_n_q;

endmodule

// File: tb/tb_disp_mux_ctrl.sv
// Bench for disp_mux_ctrl: directed scenarios then random traffic against a slot-position model.
module tb_disp_mux_ctrl;

  localparam int R = 4;
  localparam int D = 2;
  localparam int P = 2 * (R + D);

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] hex_sel;
  logic [6:0] seg_code, seg;
  logic [1:0] an_n;
  int         checks = 0;
  int         errors = 0;

  disp_mux_ctrl_if ifc ();

  disp_mux_ctrl #(
    .REFRESH_CYCLES (R),
    .DEAD_CYCLES    (D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .up       (ifc),
    .hex_sel  (hex_sel),
    .seg_code (seg_code),
    .seg      (seg),
    .an_n     (an_n)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  assign seg_code = dec(hex_sel);

  // Slot at cycle k after the reset edge: 0 show-right, 1 blank, 2 show-left, 3 blank.
  function automatic int phase(input int k);
    int q;
    if (k < D) return 3;
    q = (k - D) % P;
    if (q < R) return 0;
    if (q < R + D) return 1;
    if (q < 2 * R + D) return 2;
    return 3;
  endfunction

  function automatic bit first_dead(input int k);
    int q;
    if (k < D) return (k == 0);
    q = (k - D) % P;
    return (q == R) || (q == 2 * R + D);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model and continuous monitors.
  bit         m_init = 0;
  int         m_k;
  logic [3:0] m_d0, m_d1, m_pend;
  bit         m_pv;
  logic [1:0] m_an;
  logic [6:0] m_seg;
  logic [1:0] prev_an;
  logic [6:0] win_seg;
  bit         in_win, had_win, taint;
  int         gap, clr_cnt;

  always @(negedge clk) begin
    int ph;
    logic [3:0] exp_hex;
    if (m_init) begin
      ph      = phase(m_k);
      exp_hex = (ph == 0 || ph == 3) ? m_d0 : m_d1;
      chk("an_n", 8'(an_n), 8'(m_an));
      chk("seg", 8'(seg), 8'(m_seg));
      chk("hex_sel", 8'(hex_sel), 8'(exp_hex));
      chk("digit_ready", 8'(ifc.digit_ready), 8'(reset && !m_pv));
      chk("an_not_00", 8'(an_n == 2'b00), 8'd0);
      if (clr_cnt > 0) clr_cnt--;
      if (ifc.clear) clr_cnt = 3;
      if (an_n != 2'b11) begin
        if (!in_win || an_n != prev_an) begin
          if (had_win) chk("blank_gap", 8'(gap >= D), 8'd1);
          in_win  = 1;
          had_win = 1;
          win_seg = seg;
          taint   = (clr_cnt > 0);
        end else begin
          if (clr_cnt > 0) taint = 1;
          if (!taint) chk("seg_stable", 8'(seg), 8'(win_seg));
        end
        gap = 0;
      end else begin
        in_win = 0;
        gap++;
      end
      prev_an = an_n;
      if (reset) begin
        m_an  = (ph == 0) ? 2'b10 : (ph == 2) ? 2'b01 : 2'b11;
        m_seg = (ph == 0 || ph == 2) ? dec(exp_hex) : 7'h7F;
        if (ifc.clear) begin
          m_d0 = 4'h0;
          m_d1 = 4'h0;
          m_pv = 0;
        end else if (first_dead(m_k) && m_pv) begin
          m_d1 = m_d0;
          m_d0 = m_pend;
          m_pv = 0;
        end else if (ifc.digit_valid && !m_pv) begin
          m_pend = ifc.digit_in;
          m_pv   = 1;
        end
        m_k++;
      end
    end
    if (!reset) begin
      m_init  = 1;
      m_k     = 0;
      m_d0    = 4'h0;
      m_d1    = 4'h0;
      m_pend  = 4'h0;
      m_pv    = 0;
      m_an    = 2'b11;
      m_seg   = 7'h7F;
      in_win  = 0;
      had_win = 0;
      taint   = 0;
      gap     = 0;
      clr_cnt = 0;
      prev_an = 2'b11;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic offer(input logic [3:0] d, output int waited);
    bit ok = 0;
    waited = 0;
    ifc.digit_in    = d;
    ifc.digit_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ifc.digit_ready) begin
        ok = 1;
        break;
      end
      waited++;
    end
    step();
    ifc.digit_valid = 1'b0;
    chk("offer_accepted", 8'(ok), 8'd1);
  endtask

  // Returns at the negedge of the first lit cycle showing the requested anode pattern.
  task automatic wait_lit(input logic [1:0] an);
    bit ok = 0;
    logic [1:0] prev = an_n;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (an_n == an && prev == 2'b11) begin
        ok = 1;
        break;
      end
      prev = an_n;
    end
    chk("wait_lit", 8'(ok), 8'd1);
  endtask

  initial begin
    logic [1:0] exp_pat [P];
    int         w;
    bit         acc;

    reset           = 1'b0;
    ifc.digit_in    = 4'h0;
    ifc.digit_valid = 1'b0;
    ifc.clear       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ready_low", 8'(ifc.digit_ready), 8'd0);
    reset = 1'b1;

    // Power-up: blank for three edges, then the fixed scan pattern with digit 0 lit.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("powerup_an", 8'(an_n), 8'h03);
      chk("powerup_seg", 8'(seg), 8'h7F);
    end
    for (int i = 0; i < P; i++) exp_pat[i] = 2'b11;
    for (int i = 0; i < R; i++) begin
      exp_pat[i]         = 2'b10;
      exp_pat[R + D + i] = 2'b01;
    end
    for (int i = 0; i < 2 * P; i++) begin
      @(negedge clk);
      chk("scan_an", 8'(an_n), 8'(exp_pat[i % P]));
      chk("scan_seg", 8'(seg), (an_n == 2'b11) ? 8'h7F : 8'h40);
    end

    // Two digits committed in order: right=A, left=3.
    step();
    offer(4'h3, w);
    offer(4'hA, w);
    repeat (2 * P) step();
    wait_lit(2'b10);
    chk("right_is_A", 8'(hex_sel), 8'h0A);
    wait_lit(2'b01);
    chk("left_is_3", 8'(hex_sel), 8'h03);
    step();

    // Clear wins over an accepted offer in the same cycle.
    ifc.clear       = 1'b1;
    ifc.digit_valid = 1'b1;
    ifc.digit_in    = 4'h7;
    @(negedge clk);
    chk("clr_ready_before", 8'(ifc.digit_ready), 8'd1);
    step();
    ifc.clear       = 1'b0;
    ifc.digit_valid = 1'b0;
    @(negedge clk);
    chk("clr_ready_after", 8'(ifc.digit_ready), 8'd1);
    repeat (P) step();
    wait_lit(2'b10);
    chk("clr_right_0", 8'(hex_sel), 8'h00);
    wait_lit(2'b01);
    chk("clr_left_0", 8'(hex_sel), 8'h00);
    step();

    // Back-to-back offers: the second waits for the commit, nothing lost.
    offer(4'h5, w);
    offer(4'h6, w);
    chk("b2b_ready_dropped", 8'(w > 0), 8'd1);
    repeat (2 * P) step();
    wait_lit(2'b10);
    chk("b2b_right_6", 8'(hex_sel), 8'h06);
    wait_lit(2'b01);
    chk("b2b_left_5", 8'(hex_sel), 8'h05);

    // Reset during the left digit's slot with a digit pending.
    step();
    ifc.digit_valid = 1'b1;
    ifc.digit_in    = 4'h9;
    step();
    ifc.digit_valid = 1'b0;
    reset           = 1'b0;
    @(negedge clk);
    chk("midscan_lit_left", 8'(an_n), 8'h01);
    chk("midscan_ready_low", 8'(ifc.digit_ready), 8'd0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("midscan_an_off", 8'(an_n), 8'h03);
    chk("midscan_seg_blank", 8'(seg), 8'h7F);
    chk("midscan_pend_drop", 8'(ifc.digit_ready), 8'd1);
    chk("midscan_right_0", 8'(hex_sel), 8'h00);
    wait_lit(2'b01);
    chk("midscan_left_0", 8'(hex_sel), 8'h00);

    // Random traffic obeying the hold-until-ready rule.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      acc = ifc.digit_valid && ifc.digit_ready;
      step();
      if (!ifc.digit_valid || acc) begin
        ifc.digit_valid = ($urandom_range(0, 2) == 0);
        ifc.digit_in    = 4'($urandom_range(0, 15));
      end
      ifc.clear = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 149) != 0);
    end
    ifc.digit_valid = 1'b0;
    ifc.clear       = 1'b0;
    reset           = 1'b1;
    repeat (2 * P) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
